// File: rtl/fft_stream_bridge.sv
// fft_stream_bridge
//   Loads one frame of N samples from a valid/ready input stream into the FFT sample
//   RAM, pulses o_load_done, waits for i_calc_end, then drains N result words from
//   RAM onto a valid/ready output stream through a 2-entry skid buffer.
//
// Ports
//   i_clk, i_rstn                  clock, asynchronous active-low reset
//   i_n_samples                    frame length N, sampled on the first beat of a frame
//   i_s_valid/o_s_ready/i_s_data   input sample stream; i_s_last is checked only
//   o_ram_we/o_ram_waddr/o_ram_wdata  combinational RAM write port
//   o_load_done                    1-cycle pulse after the final sample is written
//   i_calc_end                     FFT done; honoured only while waiting for it
//   o_ram_re/o_ram_raddr           RAM read port; i_ram_rdata valid one cycle later
//   o_m_valid/i_m_ready/o_m_data/o_m_last  result stream
//   o_busy                         not idle
//   o_err_cfg                      1-cycle pulse: first beat carried an illegal N
//   o_err_last                     sticky i_s_last framing error, cleared by next frame
module fft_stream_bridge #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [ADDR_W:0]     i_n_samples,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [SAMPLE_W-1:0] i_s_data,
  input  logic                i_s_last,
  output logic                o_ram_we,
  output logic [ADDR_W-1:0]   o_ram_waddr,
  output logic [SAMPLE_W-1:0] o_ram_wdata,
  output logic                o_load_done,
  input  logic                i_calc_end,
  output logic                o_ram_re,
  output logic [ADDR_W-1:0]   o_ram_raddr,
  input  logic [DATA_W-1:0]   i_ram_rdata,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [DATA_W-1:0]   o_m_data,
  output logic                o_m_last,
  output logic                o_busy,
  output logic                o_err_cfg,
  output logic                o_err_last
);

  localparam int unsigned CW = ADDR_W + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [CW-1:0] NMin = CW'(2);
  localparam logic [CW-1:0] NMax = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          load_done_q, load_done_d;
  logic          err_cfg_q, err_cfg_d;
  logic          err_last_q, err_last_d;
  logic          rd_pend_q, rd_pend_last_q;
  // Keeps o_s_ready low while reset is asserted so every output reads 0 in reset.
  logic          out_en_q;

  logic [DATA_W-1:0] buf_data_q [2];
  logic [1:0]        buf_last_q;
  logic              buf_wptr_q, buf_rptr_q;
  logic [1:0]        buf_cnt_q;

  logic s_ready, accept, n_legal, final_beat;
  logic m_valid, pop, push, rd_issue;
  logic [1:0] occupancy;

  assign s_ready    = out_en_q & ((state_q == StIdle) | (state_q == StLoad));
  assign accept     = i_s_valid & s_ready;
  assign n_legal    = (i_n_samples >= NMin) && (i_n_samples <= NMax);
  assign final_beat = (wr_cnt_q == n_q - CW'(1));

  assign m_valid   = (buf_cnt_q != 2'd0);
  assign pop       = m_valid & i_m_ready;
  assign push      = rd_pend_q;
  assign occupancy = buf_cnt_q + {1'b0, rd_pend_q};
  // A slot freed by this cycle's pop counts as free, which sustains one beat per cycle.
  assign rd_issue  = (state_q == StDrain) && (rd_cnt_q < n_q) && ((occupancy < 2'd2) || pop);

  // Beats carrying an illegal N are accepted and dropped, so they never reach the RAM.
  assign o_s_ready   = s_ready;
  assign o_ram_we    = accept & ((state_q == StLoad) | n_legal);
  assign o_ram_waddr = wr_cnt_q[ADDR_W-1:0];
  assign o_ram_wdata = i_s_data;
  assign o_ram_re    = rd_issue;
  assign o_ram_raddr = rd_cnt_q[ADDR_W-1:0];
  assign o_m_valid   = m_valid;
  assign o_m_data    = m_valid ? buf_data_q[buf_rptr_q] : '0;
  assign o_m_last    = m_valid & buf_last_q[buf_rptr_q];
  assign o_busy      = (state_q != StIdle);
  assign o_load_done = load_done_q;
  assign o_err_cfg   = err_cfg_q;
  assign o_err_last  = err_last_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    load_done_d = 1'b0;
    err_cfg_d   = 1'b0;
    err_last_d  = err_last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (n_legal) begin
            n_d        = i_n_samples;
            wr_cnt_d   = CW'(1);
            // Beat 0 is never the final beat since N >= 2.
            err_last_d = i_s_last;
            state_d    = StLoad;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (final_beat) begin
            err_last_d  = err_last_q | ~i_s_last;
            load_done_d = 1'b1;
            wr_cnt_d    = '0;
            state_d     = StWait;
          end else begin
            err_last_d = err_last_q | i_s_last;
            wr_cnt_d   = wr_cnt_q + CW'(1);
          end
        end
      end
      StWait: begin
        if (i_calc_end) state_d = StDrain;
      end
      StDrain: begin
        if (rd_issue) rd_cnt_d = rd_cnt_q + CW'(1);
        if (pop && buf_last_q[buf_rptr_q]) begin
          rd_cnt_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q        <= StIdle;
      n_q            <= '0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      load_done_q    <= 1'b0;
      err_cfg_q      <= 1'b0;
      err_last_q     <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      out_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      load_done_q    <= load_done_d;
      err_cfg_q      <= err_cfg_d;
      err_last_q     <= err_last_d;
      rd_pend_q      <= rd_issue;
      rd_pend_last_q <= (rd_cnt_q == n_q - CW'(1));
      out_en_q       <= 1'b1;
    end
  end

  // Two-entry result buffer; occupancy plus reads in flight never exceeds two.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      buf_wptr_q    <= 1'b0;
      buf_rptr_q    <= 1'b0;
      buf_cnt_q     <= '0;
    end else begin
      if (push) begin
        buf_data_q[buf_wptr_q] <= i_ram_rdata;
        buf_last_q[buf_wptr_q] <= rd_pend_last_q;
        buf_wptr_q             <= ~buf_wptr_q;
      end
      if (pop) buf_rptr_q <= ~buf_rptr_q;
      buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fft_stream_bridge.sv
module tb_fft_stream_bridge;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [12:0] i_n_samples = '0;
  logic        i_s_valid = 1'b0;
  logic        o_s_ready;
  logic [15:0] i_s_data = '0;
  logic        i_s_last = 1'b0;
  logic        o_ram_we;
  logic [11:0] o_ram_waddr;
  logic [15:0] o_ram_wdata;
  logic        o_load_done;
  logic        i_calc_end = 1'b0;
  logic        o_ram_re;
  logic [11:0] o_ram_raddr;
  logic [31:0] i_ram_rdata = '0;
  logic        o_m_valid;
  logic        i_m_ready = 1'b0;
  logic [31:0] o_m_data;
  logic        o_m_last;
  logic        o_busy;
  logic        o_err_cfg;
  logic        o_err_last;

  fft_stream_bridge #(.SAMPLE_W(16), .DATA_W(32), .ADDR_W(12)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_n_samples(i_n_samples),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data), .i_s_last(i_s_last),
    .o_ram_we(o_ram_we), .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata),
    .o_load_done(o_load_done), .i_calc_end(i_calc_end),
    .o_ram_re(o_ram_re), .o_ram_raddr(o_ram_raddr), .i_ram_rdata(i_ram_rdata),
    .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last),
    .o_busy(o_busy), .o_err_cfg(o_err_cfg), .o_err_last(o_err_last)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference state: the stimulus of the current frame and what must come out of it.
  logic [15:0] samp    [4096];
  logic [15:0] ram_in  [4096];
  logic [31:0] mem_out [4096];
  int cur_n = 0, w_idx = 0, o_idx = 0, rd_tb = 0, ld_cnt = 0, cfg_cnt = 0;
  int lastw_cyc = 0, ld_cyc = 0, fv_cyc = 0, lb_cyc = 0, calc_cyc = 0;
  bit seen_v = 0, wr_ok = 1, busy_forbid = 0;
  logic [31:0] first_d = '0, last_d = '0;
  bit pv = 0, pr = 0, pl = 0;
  logic [31:0] pd = '0;
  int rdy_mode = 0, stall_left = 0;
  bit stall_done = 0;

  // Stand-in for the FFT core: result word i derived from sample i.
  function automatic logic [31:0] fft_f(input logic [15:0] s, input int i);
    return {s ^ 16'hA5A5, s} + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({o_s_ready, o_ram_we, o_load_done, o_ram_re, o_m_valid, o_m_last,
                             o_busy, o_err_cfg, o_err_last}), 32'd0);
    chk({tag, "_addr"}, 32'({o_ram_waddr, o_ram_raddr}), 32'd0);
    chk({tag, "_wdata"}, 32'(o_ram_wdata), 32'd0);
    chk({tag, "_mdata"}, o_m_data, 32'd0);
  endtask

  // RAM model: combinational-address write, one-cycle read; garbage when not read.
  always @(posedge i_clk) begin
    if (o_ram_we) ram_in[o_ram_waddr] <= o_ram_wdata;
    i_ram_rdata <= o_ram_re ? mem_out[o_ram_raddr] : $urandom;
  end

  // Output sink ready pattern.
  always @(posedge i_clk) begin
    #1;
    if (stall_left > 0) begin
      i_m_ready = 1'b0;
      stall_left--;
    end else if (rdy_mode == 1 && !stall_done && o_idx == 6) begin
      stall_done = 1;
      stall_left = 4;
      i_m_ready  = 1'b0;
    end else begin
      i_m_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Compare process, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      pv = 0;
    end else begin
      if (o_ram_we) begin
        chk("write_allowed", 32'(wr_ok && w_idx < cur_n), 32'd1);
        if (w_idx < cur_n) begin
          chk("waddr", 32'(o_ram_waddr), 32'(w_idx & 4095));
          chk("wdata", 32'(o_ram_wdata), 32'(samp[w_idx]));
        end
        w_idx++;
        if (w_idx == cur_n) lastw_cyc = cyc;
      end
      if (o_load_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end
      if (o_err_cfg) cfg_cnt++;
      if (busy_forbid) chk("busy_low", 32'(o_busy), 32'd0);
      if (o_ram_re) begin
        chk("read_in_range", 32'(rd_tb < cur_n), 32'd1);
        chk("raddr", 32'(o_ram_raddr), 32'(rd_tb & 4095));
        rd_tb++;
      end
      if (pv && !pr) begin
        chk("stall_valid", 32'(o_m_valid), 32'd1);
        chk("stall_data", o_m_data, pd);
        chk("stall_last", 32'(o_m_last), 32'(pl));
      end
      if (o_m_valid && !seen_v) begin
        seen_v = 1;
        fv_cyc = cyc;
      end
      if (o_m_valid && i_m_ready) begin
        chk("beat_expected", 32'(o_idx < cur_n), 32'd1);
        if (o_idx < cur_n) begin
          chk("m_data", o_m_data, fft_f(samp[o_idx], o_idx));
          chk("m_last", 32'(o_m_last), 32'(o_idx == cur_n - 1));
          if (o_idx == 0) first_d = o_m_data;
          if (o_idx == cur_n - 1) begin
            last_d = o_m_data;
            lb_cyc = cyc;
          end
        end
        o_idx++;
      end
      pv = o_m_valid;
      pr = i_m_ready;
      pd = o_m_data;
      pl = o_m_last;
    end
  end

  task automatic put_beat(input int n, input logic [15:0] d, input bit l);
    int t = 0;
    bit acc;
    i_n_samples = 13'(n);
    i_s_data    = d;
    i_s_last    = l;
    i_s_valid   = 1'b1;
    do begin
      @(negedge i_clk);
      acc = o_s_ready;
      @(posedge i_clk);
      #1;
      t++;
    end while (!acc && t < 50);
    chk("s_ready_seen", 32'(acc), 32'd1);
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    i_s_data  = '0;
  endtask

  // One frame: load, fake FFT, drain. stop_after > 0 returns once that many beats are out.
  task automatic run_frame(input int n, input int lastpos, input bit seqdata, input bit stray,
                           input int rmode, input int stop_after);
    int t;
    int lim;
    bit exp_err;
    exp_err = (lastpos != n - 1);
    cur_n = n; w_idx = 0; o_idx = 0; rd_tb = 0; ld_cnt = 0; seen_v = 0;
    rdy_mode = rmode; stall_done = 0;
    for (int k = 0; k < n; k++) samp[k] = seqdata ? 16'(k + 1) : 16'($urandom);
    for (int k = 0; k < n; k++) begin
      if (!seqdata && $urandom_range(0, 3) == 0) tick(1);
      if (stray && k == n / 2) i_calc_end = 1'b1;
      put_beat(n, samp[k], k == lastpos);
      i_calc_end = 1'b0;
      if (k == 0) chk("err_last_first_beat", 32'(o_err_last), 32'(lastpos == 0));
    end
    t = 0;
    while (ld_cnt == 0 && t < 20) begin
      tick(1);
      t++;
    end
    chk("load_done_seen", 32'(ld_cnt), 32'd1);
    chk("load_done_cycle", 32'(ld_cyc), 32'(lastw_cyc + 1));
    chk("writes", 32'(w_idx), 32'(n));
    chk("no_early_reads", 32'(rd_tb), 32'd0);
    chk("busy_wait", 32'(o_busy), 32'd1);
    chk("err_last_wait", 32'(o_err_last), 32'(exp_err));
    for (int i = 0; i < n; i++) mem_out[i] = fft_f(ram_in[i], i);
    tick(3);
    chk("no_reads_in_wait", 32'(rd_tb), 32'd0);
    i_calc_end = 1'b1;
    calc_cyc = cyc;
    tick(1);
    i_calc_end = 1'b0;
    chk("err_last_drain", 32'(o_err_last), 32'(exp_err));
    lim = (stop_after > 0) ? stop_after : n;
    t = 0;
    while (o_idx < lim && t < 20 * n + 100) begin
      tick(1);
      t++;
    end
    if (stop_after > 0) begin
      chk("partial_beats", 32'(o_idx), 32'(stop_after));
      return;
    end
    chk("beats", 32'(o_idx), 32'(n));
    chk("idle_after", 32'(o_busy), 32'd0);
    chk("reads", 32'(rd_tb), 32'(n));
    chk("load_done_once", 32'(ld_cnt), 32'd1);
    if (rmode == 0) begin
      chk("first_valid_cycle", 32'(fv_cyc), 32'(calc_cyc + 3));
      chk("last_beat_cycle", 32'(lb_cyc), 32'(calc_cyc + n + 2));
    end
  endtask

  initial begin
    int c0;
    tick(3);
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick(2);

    // Normal frame with literal pins on the model.
    run_frame(8, 7, 1, 0, 0, 0);
    chk("first_word_literal", first_d, 32'hA5A4_0001);
    chk("last_word_literal", last_d, 32'hA5AD_000F);
    chk("err_last_clean", 32'(o_err_last), 32'd0);

    // Backpressure.
    run_frame(16, 15, 0, 0, 1, 0);

    // Illegal N on first beats.
    wr_ok = 0;
    busy_forbid = 1;
    c0 = cfg_cnt;
    put_beat(1, 16'h1234, 1'b0);
    chk("err_cfg_pulse_n1", 32'(o_err_cfg), 32'd1);
    tick(3);
    chk("err_cfg_count_1", 32'(cfg_cnt), 32'(c0 + 1));
    put_beat(0, 16'h5678, 1'b0);
    chk("err_cfg_pulse_n0", 32'(o_err_cfg), 32'd1);
    tick(3);
    chk("err_cfg_count_2", 32'(cfg_cnt), 32'(c0 + 2));
    wr_ok = 1;
    busy_forbid = 0;

    // Framing error, sticky until the next frame's first beat.
    run_frame(8, 3, 0, 0, 0, 0);
    tick(2);
    chk("err_last_sticky_idle", 32'(o_err_last), 32'd1);
    run_frame(5, 4, 0, 0, 1, 0);

    // Stray i_calc_end during LOAD plus full-size frame.
    run_frame(4096, 4095, 0, 1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 40);
      run_frame(n, n - 1, 0, 0, 1, 0);
    end

    // Reset during drain.
    run_frame(8, 7, 0, 0, 0, 3);
    #2;
    i_rstn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick(2);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick(2);
    chk("idle_after_reset", 32'(o_busy), 32'd0);
    run_frame(4, 3, 0, 0, 1, 0);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
